axi_ram_ctrl: RTL and testbench
===============================

// Module: axi_ram_ctrl
// PURPOSE
//  AXI4 slave that is the initiator side of the 64-bit byte-enabled BRAM port (addr/din/wen/dout).
//  Converts AXI4 read/write bursts from the CPU bus into single-port RAM cycles.
//  It owns the RAM port exclusively and serves one burst at a time.
// PARAMETERS
//  ID_W    4   AXI ID width
//  ADDR_W  32  AXI address width
//  RAM_AW  16  RAM word-address width; RAM spans 2**(RAM_AW+3) bytes
// PORTS
//  clk       in   1       clock; RAM samples on falling edge, this block on rising edge
//  rst       in   1       synchronous, active-high reset
//  aw{id,addr,len,size,burst,valid} in ID_W/ADDR_W/8/3/2/1; awready out 1
//  wdata in 64, wstrb in 8, wlast in 1, wvalid in 1; wready out 1
//  bid out ID_W, bresp out 2, bvalid out 1; bready in 1
//  ar{id,addr,len,size,burst,valid} in ID_W/ADDR_W/8/3/2/1; arready out 1
//  rid out ID_W, rdata out 64, rresp out 2, rlast out 1, rvalid out 1; rready in 1
//  ram_addr  out  RAM_AW  RAM word address = AXI addr[RAM_AW+2:3]
//  ram_din   out  64      RAM write data
//  ram_wen   out  8       RAM byte write enables
//  ram_dout  in   64      RAM read data, valid at the rising edge after ram_addr is stable
// BEHAVIOUR
//  - FSM: IDLE, WR, WRESP, RD, RDATA. Reset: IDLE; all valids/readies 0, ram_wen 0, ram_addr 0, bresp/rresp 0.
//  - IDLE: awready/arready are combinational from state, valids and the last_rd flag. If both
//    valids are high, serve the opposite of last_rd; reset sets last_rd=0, so the read wins first.
//    On handshake: latch id, len, burst, word address; clear beat count; go to WR or RD.
//  - awsize/arsize ignored; every beat is 64 bits. FIXED keeps the address. INCR and WRAP both
//    increment by 1 word. The word address wraps modulo 2**RAM_AW.
//  - WR: wready=1. ram_wen = wvalid ? wstrb : 0 (combinational). ram_din = wdata.
//    On a W handshake, advance the address and count.
//    On wlast: go to WRESP. bresp=SLVERR(2'b10) if beats != len+1, else OKAY.
//  - WRESP: bvalid=1, bid=latched id; hold until bready, then IDLE.
//  - RD: drive ram_addr (ram_wen=0) for one cycle -> RDATA.
//  - RDATA: rvalid=1, rdata=ram_dout (pass-through, address held so dout stays stable),
//    rlast=(count==len), rresp=OKAY. Hold all of these until rready.
//    On handshake: last beat -> IDLE, else advance -> RD. Throughput is 1 read beat per 2 cycles.
//    Write throughput is 1 beat per cycle.
//  - ram_wen is 0 in every state except WR.
//  - rst mid-burst: immediate return to IDLE; the burst is dropped, with no B or R issued.
// CONFIGURATION
//  AXI_RAM_RANGE_CHECK_EN defined:
//    - An address beat with addr[ADDR_W-1:RAM_AW+3] != 0 is a decode error.
//    - Writes: ram_wen forced 0, bresp=DECERR(2'b11).
//    - Reads: rdata=0, rresp=DECERR.
//  Not defined: upper address bits are ignored (aliasing) and the response is OKAY.
// TESTING
//  1. AW addr 0x10, len 0; W data 0x1122334455667788, strb 0x0F -> ram_wen 0x0F at ram_addr 2; bresp 0.
//     Then AR addr 0x10 -> rdata 0x0000000055667788 if RAM was zero.
//  2. AW INCR len 3 at 0x7FFF8 -> words 0xFFFF,0,1,2 written.
//     AR of the same burst -> 4 beats, rlast on the 4th only.
//  3. awvalid and arvalid both high after reset -> read served first, then the write; next tie -> read.
//  4. rready held low 5 cycles in RDATA -> rvalid/rdata/rlast stable; address does not advance.
//  5. AW len 3, wlast on beat 2 -> bresp 2'b10 after 2 writes; FIXED burst -> all beats at one address.
//  6. rst asserted in WR beat 1 -> next cycle IDLE, wready 0, ram_wen 0, no bvalid.
//     With AXI_RAM_RANGE_CHECK_EN, AW addr 0x80000 -> no write, bresp 2'b11.

Source files
------------

// File: rtl/axi_ram_ctrl.sv
// AXI4 slave that turns read/write bursts into cycles on a single-port 64-bit byte-enabled RAM.
// Optional feature: define AXI_RAM_RANGE_CHECK_EN to answer out-of-range bursts with DECERR.
module axi_ram_ctrl #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int RAM_AW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ID_W-1:0]   awid,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [7:0]        awlen,
   input  logic [2:0]        awsize,
   input  logic [1:0]        awburst,
   input  logic              awvalid,
   output logic              awready,
   input  logic [63:0]       wdata,
   input  logic [7:0]        wstrb,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready,
   output logic [ID_W-1:0]   bid,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [ID_W-1:0]   arid,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [7:0]        arlen,
   input  logic [2:0]        arsize,
   input  logic [1:0]        arburst,
   input  logic              arvalid,
   output logic              arready,
   output logic [ID_W-1:0]   rid,
   output logic [63:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [63:0]       ram_din,
   output logic [7:0]        ram_wen,
   input  logic [63:0]       ram_dout
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WR    = 3'd1;
   localparam logic [2:0] S_WRESP = 3'd2;
   localparam logic [2:0] S_RD    = 3'd3;
   localparam logic [2:0] S_RDATA = 3'd4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_FIXED = 2'b00;

   logic [2:0]        state;
   logic [ID_W-1:0]   id_q;
   logic [7:0]        len_q;
   logic [1:0]        burst_q;
   logic [RAM_AW-1:0] addr_q;
   logic [8:0]        count_q;
   logic              last_rd;
   logic              dec_err_q;
   logic [1:0]        bresp_q;

   logic              pick_rd;
   logic              aw_hs;
   logic              ar_hs;
   logic              w_hs;
   logic              beat_last;
   logic              aw_dec;
   logic              ar_dec;
   logic [RAM_AW-1:0] addr_next;

   // awsize/arsize and the byte-offset bits carry no information for a fixed 64-bit beat.
   logic unused_bits;
   assign unused_bits = ^{awsize, arsize, awaddr, araddr};

`ifdef AXI_RAM_RANGE_CHECK_EN
   assign aw_dec = |awaddr[ADDR_W-1:RAM_AW+3];
   assign ar_dec = |araddr[ADDR_W-1:RAM_AW+3];
`else
   assign aw_dec = 1'b0;
   assign ar_dec = 1'b0;
`endif

   // On a tie the channel not served last time wins; last_rd resets low so reads win first.
   assign pick_rd = arvalid && (!awvalid || !last_rd);
   assign arready = (state == S_IDLE) && pick_rd;
   assign awready = (state == S_IDLE) && awvalid && !pick_rd;
   assign aw_hs   = awvalid && awready;
   assign ar_hs   = arvalid && arready;

   assign wready  = (state == S_WR);
   assign w_hs    = wvalid && wready;

   assign beat_last = (count_q == {1'b0, len_q});
   assign addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + RAM_AW'(1);

   assign ram_addr = addr_q;
   assign ram_din  = wdata;
   assign ram_wen  = (state == S_WR && wvalid && !dec_err_q) ? wstrb : 8'h00;

   assign bvalid = (state == S_WRESP);
   assign bid    = id_q;
   assign bresp  = bresp_q;

   assign rvalid = (state == S_RDATA);
   assign rid    = id_q;
   assign rdata  = (state == S_RDATA && !dec_err_q) ? ram_dout : 64'h0;
   assign rresp  = (state == S_RDATA && dec_err_q) ? RESP_DECERR : RESP_OKAY;
   assign rlast  = (state == S_RDATA) && beat_last;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      // NOTE: rst is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
      if (rst) begin
         state     <= S_IDLE;
         id_q      <= '0;
         len_q     <= '0;
         burst_q   <= '0;
         addr_q    <= '0;
         count_q   <= '0;
         last_rd   <= 1'b0;
         dec_err_q <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         case (state)
            S_IDLE: begin
               if (ar_hs) begin
                  id_q      <= arid;
                  len_q     <= arlen;
                  burst_q   <= arburst;
                  addr_q    <= araddr[RAM_AW+2:3];
                  count_q   <= '0;
                  dec_err_q <= ar_dec;
                  last_rd   <= 1'b1;
                  state     <= S_RD;
               end else if (aw_hs) begin
                  id_q      <= awid;
                  len_q     <= awlen;
                  burst_q   <= awburst;
                  addr_q    <= awaddr[RAM_AW+2:3];
                  count_q   <= '0;
                  dec_err_q <= aw_dec;
                  last_rd   <= 1'b0;
                  state     <= S_WR;
               end
            end
            S_WR: begin
               if (w_hs) begin
                  addr_q  <= addr_next;
                  count_q <= count_q + 9'd1;
                  if (wlast) begin
                     state <= S_WRESP;
                     if (dec_err_q)
                        bresp_q <= RESP_DECERR;
                     else if (!beat_last)
                        bresp_q <= RESP_SLVERR;
                     else
                        bresp_q <= RESP_OKAY;
                  end
               end
            end
            S_WRESP: begin
               if (bready)
                  state <= S_IDLE;
            end
            S_RD: begin
               state <= S_RDATA;
            end
            S_RDATA: begin
               // Address is held while stalled so ram_dout stays valid for the pending beat.
               if (rready) begin
                  if (beat_last) begin
                     state <= S_IDLE;
                  end else begin
                     addr_q  <= addr_next;
                     count_q <= count_q + 9'd1;
                     state   <= S_RD;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_ram_ctrl.sv
// Randomised scoreboard bench for axi_ram_ctrl with a word-array reference memory model.
module tb_axi_ram_ctrl;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int RAM_AW = 16;
`ifdef AXI_RAM_RANGE_CHECK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [ID_W-1:0]   awid;
   logic [ADDR_W-1:0] awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awvalid;
   logic              awready;
   logic [63:0]       wdata;
   logic [7:0]        wstrb;
   logic              wlast;
   logic              wvalid;
   logic              wready;
   logic [ID_W-1:0]   bid;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid;
   logic              arready;
   logic [ID_W-1:0]   rid;
   logic [63:0]       rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;
   logic [RAM_AW-1:0] ram_addr;
   logic [63:0]       ram_din;
   logic [7:0]        ram_wen;
   logic [63:0]       ram_dout;

   axi_ram_ctrl #(.ID_W(ID_W), .ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) dut (
      .clk(clk), .rst(rst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_wen(ram_wen), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } b_item_t;
   typedef struct { logic [ID_W-1:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_item_t;
   typedef struct { logic [RAM_AW-1:0] addr; logic [7:0] wen; logic [63:0] din; } w_item_t;

   b_item_t b_q[$];
   r_item_t r_q[$];
   w_item_t w_q[$];
   bit      order_q[$];   // 1 = read accepted next, 0 = write accepted next

   logic [63:0] mem     [0:65535];
   logic [63:0] ref_mem [0:65535];

   int n_checks = 0;
   int n_fail   = 0;
   bit last_was_read = 1'b0;
   int r_stall = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name, input string detail);
      n_checks++;
      n_fail++;
      $display("FAIL %s: %s (t=%0t)", name, detail, $time);
   endtask

   task automatic finish_test();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   task automatic timeout(input string name);
      flag(name, "timed out waiting for the DUT");
      finish_test();
   endtask

   function automatic bit is_dec(input logic [31:0] a);
      return RANGE_EN && (a[31:19] != 13'h0);
   endfunction

   // Bench RAM: samples address/write enables on the falling edge, read data registered there.
   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 64'h0;
         ref_mem[i] = 64'h0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 8; k++)
            if (ram_wen[k]) mem[ram_addr][k*8 +: 8] = ram_din[k*8 +: 8];
         ram_dout <= mem[ram_addr];
      end
   end

   // RAM write monitor
   initial begin
      w_item_t we;
      forever begin
         @(negedge clk);
         if (!rst && ram_wen != 8'h00) begin
            if (w_q.size() == 0) begin
               flag("ram_write_unexpected", $sformatf("addr %h wen %h", ram_addr, ram_wen));
            end else begin
               we = w_q.pop_front();
               check("ram_addr", 64'(ram_addr), 64'(we.addr));
               check("ram_wen", 64'(ram_wen), 64'(we.wen));
               check("ram_din", ram_din, we.din);
            end
         end
      end
   end

   // Address-channel arbitration monitor
   initial begin
      bit exp_rd;
      forever begin
         @(negedge clk);
         if (!rst && ((awvalid && awready) || (arvalid && arready))) begin
            if (awvalid && awready && arvalid && arready)
               flag("addr_both", "aw and ar accepted in the same cycle");
            else if (order_q.size() == 0)
               flag("addr_unexpected", $sformatf("awready %b arready %b", awready, arready));
            else begin
               exp_rd = order_q.pop_front();
               check("arb_read_first", 64'(arvalid && arready), 64'(exp_rd));
            end
         end
      end
   end

   // B monitor
   initial begin
      b_item_t be;
      forever begin
         @(negedge clk);
         if (!rst && bvalid && bready) begin
            if (b_q.size() == 0) begin
               flag("b_unexpected", $sformatf("bid %h bresp %h", bid, bresp));
            end else begin
               be = b_q.pop_front();
               check("bid", 64'(bid), 64'(be.id));
               check("bresp", 64'(bresp), 64'(be.resp));
            end
         end
      end
   end

   // R monitor, including stability of a stalled beat
   initial begin
      r_item_t re;
      bit held = 1'b0;
      logic [63:0] h_data;
      logic h_last;
      logic [ID_W-1:0] h_id;
      logic [RAM_AW-1:0] h_addr;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 1'b0;
            continue;
         end
         if (held && !rvalid) flag("rvalid_dropped", "rvalid fell before rready");
         if (rvalid) begin
            if (held) begin
               check("r_hold_data", rdata, h_data);
               check("r_hold_last", 64'(rlast), 64'(h_last));
               check("r_hold_id", 64'(rid), 64'(h_id));
               check("r_hold_addr", 64'(ram_addr), 64'(h_addr));
            end
            if (rready) begin
               if (r_q.size() == 0) begin
                  flag("r_unexpected", $sformatf("rdata %h rlast %b", rdata, rlast));
               end else begin
                  re = r_q.pop_front();
                  check("rid", 64'(rid), 64'(re.id));
                  check("rdata", rdata, re.data);
                  check("rresp", 64'(rresp), 64'(re.resp));
                  check("rlast", 64'(rlast), 64'(re.last));
               end
               held = 1'b0;
            end else begin
               held   = 1'b1;
               h_data = rdata;
               h_last = rlast;
               h_id   = rid;
               h_addr = ram_addr;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   // Response-ready drivers with random back-pressure and occasional 5-cycle stalls
   initial begin
      rready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (r_stall > 0) begin
            rready = 1'b0;
            r_stall--;
         end else if ($urandom_range(0, 9) == 0) begin
            rready  = 1'b0;
            r_stall = 4;
         end else begin
            rready = ($urandom_range(0, 2) != 0);
         end
      end
   end

   initial begin
      bready = 1'b0;
      forever begin
         @(posedge clk); #1;
         bready = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      #3ms;
      timeout("global_watchdog");
   end

   // ---------------- stimulus helpers (all start and end just after a rising edge) ---------------
   task automatic set_aw(input logic [ID_W-1:0] i_id, input logic [31:0] i_addr,
                         input logic [7:0] i_len, input logic [1:0] i_burst);
      awid = i_id; awaddr = i_addr; awlen = i_len; awburst = i_burst;
      awsize = 3'($urandom); awvalid = 1'b1;
   endtask

   task automatic set_ar(input logic [ID_W-1:0] i_id, input logic [31:0] i_addr,
                         input logic [7:0] i_len, input logic [1:0] i_burst);
      arid = i_id; araddr = i_addr; arlen = i_len; arburst = i_burst;
      arsize = 3'($urandom); arvalid = 1'b1;
   endtask

   task automatic wait_aw();
      int n = 0;
      do begin
         @(negedge clk);
         if (++n > 300) timeout("aw_handshake");
      end while (!awready);
      last_was_read = 1'b0;
      @(posedge clk); #1;
      awvalid = 1'b0;
   endtask

   // Expected read beats come from the reference memory as it stands when AR is accepted.
   task automatic wait_ar(input logic [ID_W-1:0] i_id, input logic [31:0] i_addr,
                          input logic [7:0] i_len, input logic [1:0] i_burst);
      int n = 0;
      logic [RAM_AW-1:0] a;
      bit dec;
      do begin
         @(negedge clk);
         if (++n > 300) timeout("ar_handshake");
      end while (!arready);
      a   = i_addr[18:3];
      dec = is_dec(i_addr);
      for (int i = 0; i <= int'(i_len); i++) begin
         r_q.push_back('{id: i_id, data: dec ? 64'h0 : ref_mem[a],
                         resp: dec ? 2'b11 : 2'b00, last: (i == int'(i_len))});
         if (i_burst != 2'b00) a = a + 16'd1;
      end
      last_was_read = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   task automatic w_phase(input logic [ID_W-1:0] i_id, input logic [31:0] i_addr,
                          input logic [7:0] i_len, input logic [1:0] i_burst, input int nbeats,
                          input bit give_last, input bit fixed_data, input logic [63:0] fdata,
                          input logic [7:0] fstrb);
      logic [RAM_AW-1:0] a = i_addr[18:3];
      bit dec = is_dec(i_addr);
      for (int b = 0; b < nbeats; b++) begin
         if (!fixed_data && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         wdata = fixed_data ? fdata : {$urandom, $urandom};
         wstrb = fixed_data ? fstrb : ($urandom_range(0, 1) ? 8'hFF : 8'($urandom));
         wlast = give_last && (b == nbeats - 1);
         if (!dec && wstrb != 8'h00) begin
            w_q.push_back('{addr: a, wen: wstrb, din: wdata});
            for (int k = 0; k < 8; k++)
               if (wstrb[k]) ref_mem[a][k*8 +: 8] = wdata[k*8 +: 8];
         end
         wvalid = 1'b1;
         begin
            int n = 0;
            do begin
               @(negedge clk);
               if (++n > 300) timeout("w_handshake");
            end while (!wready);
         end
         @(posedge clk); #1;
         wvalid = 1'b0;
         wlast  = 1'b0;
         if (i_burst != 2'b00) a = a + 16'd1;
      end
      if (give_last)
         b_q.push_back('{id: i_id,
                         resp: dec ? 2'b11 : (nbeats != int'(i_len) + 1) ? 2'b10 : 2'b00});
   endtask

   task automatic wait_b_drain();
      int n = 0;
      while (b_q.size() != 0) begin
         @(negedge clk);
         if (++n > 500) timeout("b_response");
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_r_drain();
      int n = 0;
      while (r_q.size() != 0) begin
         @(negedge clk);
         if (++n > 3000) timeout("r_response");
      end
      @(posedge clk); #1;
   endtask

   task automatic do_write(input logic [ID_W-1:0] i_id, input logic [31:0] i_addr,
                           input logic [7:0] i_len, input logic [1:0] i_burst, input int nbeats);
      order_q.push_back(1'b0);
      set_aw(i_id, i_addr, i_len, i_burst);
      wait_aw();
      w_phase(i_id, i_addr, i_len, i_burst, nbeats, 1'b1, 1'b0, 64'h0, 8'h0);
      wait_b_drain();
   endtask

   task automatic do_read(input logic [ID_W-1:0] i_id, input logic [31:0] i_addr,
                          input logic [7:0] i_len, input logic [1:0] i_burst);
      order_q.push_back(1'b1);
      set_ar(i_id, i_addr, i_len, i_burst);
      wait_ar(i_id, i_addr, i_len, i_burst);
      wait_r_drain();
   endtask

   // Both address channels presented together; the one not served last time must win.
   task automatic do_tie(input logic [ID_W-1:0] w_id, input logic [31:0] w_addr,
                         input logic [7:0] w_len, input logic [1:0] w_burst,
                         input logic [ID_W-1:0] r_id, input logic [31:0] r_addr,
                         input logic [7:0] r_len, input logic [1:0] r_burst);
      bit read_first = !last_was_read;
      order_q.push_back(read_first);
      order_q.push_back(!read_first);
      set_aw(w_id, w_addr, w_len, w_burst);
      set_ar(r_id, r_addr, r_len, r_burst);
      if (read_first) begin
         wait_ar(r_id, r_addr, r_len, r_burst);
         wait_r_drain();
         wait_aw();
         w_phase(w_id, w_addr, w_len, w_burst, int'(w_len) + 1, 1'b1, 1'b0, 64'h0, 8'h0);
         wait_b_drain();
      end else begin
         wait_aw();
         w_phase(w_id, w_addr, w_len, w_burst, int'(w_len) + 1, 1'b1, 1'b0, 64'h0, 8'h0);
         wait_b_drain();
         wait_ar(r_id, r_addr, r_len, r_burst);
         wait_r_drain();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      last_was_read = 1'b0;
   endtask

   // ------------------------------------ main sequence ------------------------------------------
   initial begin
      logic [31:0] addr;
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [15:0] word;
      int          nbeats;
      int          kind;

      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      @(posedge clk); #1;
      do_reset();

      @(negedge clk);
      check("reset_awready", 64'(awready), 64'h0);
      check("reset_arready", 64'(arready), 64'h0);
      check("reset_wready", 64'(wready), 64'h0);
      check("reset_bvalid", 64'(bvalid), 64'h0);
      check("reset_rvalid", 64'(rvalid), 64'h0);
      check("reset_ram_wen", 64'(ram_wen), 64'h0);
      check("reset_ram_addr", 64'(ram_addr), 64'h0);
      check("reset_bresp", 64'(bresp), 64'h0);
      check("reset_rresp", 64'(rresp), 64'h0);
      @(posedge clk); #1;

      // Ties right after reset: read first, then the write; the next tie goes to the read again.
      do_tie(4'h1, 32'h0000_0400, 8'd1, 2'b01, 4'h2, 32'h0000_0440, 8'd0, 2'b01);
      do_tie(4'h3, 32'h0000_0480, 8'd0, 2'b01, 4'h4, 32'h0000_0400, 8'd1, 2'b01);

      // Single-beat partial-strobe write at byte 0x10 then read back.
      order_q.push_back(1'b0);
      set_aw(4'h5, 32'h0000_0010, 8'd0, 2'b01);
      wait_aw();
      w_phase(4'h5, 32'h0000_0010, 8'd0, 2'b01, 1, 1'b1, 1'b1, 64'h1122_3344_5566_7788, 8'h0F);
      wait_b_drain();
      do_read(4'h6, 32'h0000_0010, 8'd0, 2'b01);

      // INCR burst wrapping the top of the word space, read back under a forced stall.
      do_write(4'h7, 32'h0007_FFF8, 8'd3, 2'b01, 4);
      r_stall = 7;
      do_read(4'h8, 32'h0007_FFF8, 8'd3, 2'b01);

      // Early wlast gives SLVERR; FIXED bursts stay on one word.
      do_write(4'h9, 32'h0000_0300, 8'd3, 2'b01, 2);
      do_write(4'hA, 32'h0000_0500, 8'd3, 2'b00, 4);
      do_read(4'hB, 32'h0000_0500, 8'd3, 2'b00);
      do_read(4'hC, 32'h0000_0300, 8'd3, 2'b01);

      // Just beyond the RAM: aliases to word 0, or DECERR when range checking is built in.
      do_write(4'hD, 32'h0008_0000, 8'd0, 2'b01, 1);
      do_read(4'hE, 32'h0008_0000, 8'd1, 2'b01);
      do_read(4'hF, 32'h0000_0000, 8'd1, 2'b01);

      for (int it = 0; it < 50; it++) begin
         kind  = $urandom_range(0, 4);
         len   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 4));
         burst = 2'($urandom_range(0, 2));
         word  = $urandom_range(0, 1) ? 16'($urandom_range(0, 31))
                                      : 16'hFFF0 + 16'($urandom_range(0, 15));
         addr  = {13'h0, word, 3'($urandom)};
         if ($urandom_range(0, 7) == 0) addr[31:19] = 13'($urandom_range(1, 8191));
         nbeats = ($urandom_range(0, 5) == 0) ? $urandom_range(1, int'(len) + 2) : int'(len) + 1;
         case (kind)
            0, 1:    do_write(4'($urandom), addr, len, burst, nbeats);
            2, 3:    do_read(4'($urandom), addr, len, burst);
            default: do_tie(4'($urandom), addr, len, burst,
                            4'($urandom), {13'h0, 16'($urandom_range(0, 31)), 3'h0}, len, 2'b01);
         endcase
      end

      // Reset in the middle of a write burst: dropped, no response, back to idle.
      order_q.push_back(1'b0);
      set_aw(4'h5, 32'h0000_0200, 8'd3, 2'b01);
      wait_aw();
      w_phase(4'h5, 32'h0000_0200, 8'd3, 2'b01, 1, 1'b0, 1'b0, 64'h0, 8'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      last_was_read = 1'b0;
      wdata = 64'hDEAD_BEEF_0BAD_F00D;
      wstrb = 8'hFF;
      wvalid = 1'b1;
      @(negedge clk);
      check("rst_mid_wready", 64'(wready), 64'h0);
      check("rst_mid_ram_wen", 64'(ram_wen), 64'h0);
      check("rst_mid_bvalid", 64'(bvalid), 64'h0);
      @(posedge clk); #1;
      wvalid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("rst_mid_no_b", 64'(bvalid), 64'h0);
      end
      @(posedge clk); #1;
      do_read(4'h6, 32'h0000_0200, 8'd3, 2'b01);

      repeat (10) @(posedge clk);
      check("w_q_drained", 64'(w_q.size()), 64'h0);
      check("order_q_drained", 64'(order_q.size()), 64'h0);
      finish_test();
   end

endmodule
